packetizer_rr_fifo: RTL and testbench

//  Clocked, parametrised packetizer. Merges NUM_SRC producer channels into one packet stream toward the router.

---
 rtl/pkt_pkg.sv | 26 ++
 rtl/pkt_sync_fifo.sv | 53 +++++
 rtl/packetizer_rr_fifo.sv | 98 +++++++++
 tb/tb_packetizer_rr_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared widths, field offsets and flit packing helper for the packetizer
package pkt_pkg;
  localparam int NUM_SRC_DEF    = 4;
  localparam int ADDR_W_DEF     = 4;
  localparam int OP_W_DEF       = 4;
  localparam int DATA_W_DEF     = 25;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  localparam int FLIT_W   = ADDR_W_DEF + OP_W_DEF + DATA_W_DEF;
  localparam int OP_LSB   = DATA_W_DEF;
  localparam int ADDR_LSB = OP_W_DEF + DATA_W_DEF;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic flit_t pack_flit(input logic [ADDR_W_DEF-1:0] addr,
                                      input logic [OP_W_DEF-1:0]   op,
                                      input logic [DATA_W_DEF-1:0] data);
    flit_t f;
    f = '0;
    f[ADDR_LSB +: ADDR_W_DEF] = addr;
    f[OP_LSB +: OP_W_DEF]     = op;
    f[0 +: DATA_W_DEF]        = data;
    return f;
  endfunction
endpackage

// File: rtl/pkt_sync_fifo.sv
// rtl/pkt_sync_fifo.sv - synchronous FIFO with a dedicated occupancy register
module pkt_sync_fifo import pkt_pkg::*; #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// File: rtl/packetizer_rr_fifo.sv
// rtl/packetizer_rr_fifo.sv - round-robin merge of producer channels into a queued flit stream
module packetizer_rr_fifo import pkt_pkg::*; #(
  parameter  int NUM_SRC    = NUM_SRC_DEF,
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int OP_W       = OP_W_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int PKT_W      = ADDR_W + OP_W + DATA_W,
  localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*OP_W-1:0]   src_op,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [PKT_W-1:0]          pkt_data,
  output logic [SRC_W-1:0]          pkt_src,
  output logic [FCNT_W-1:0]         fifo_count,
  output logic [CNT_W-1:0]          sent_cnt
);
  logic [ADDR_W-1:0] addr_a [NUM_SRC];
  logic [OP_W-1:0]   op_a   [NUM_SRC];
  logic [DATA_W-1:0] data_a [NUM_SRC];
  logic [SRC_W-1:0]  ptr_q, ptr_d, grant_idx, idx;
  logic              grant_vld, full, empty, accept, pop;
  logic [PKT_W-1:0]  flit;
  logic [SRC_W+PKT_W-1:0] head;
  logic [CNT_W-1:0]  sent_q, sent_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign addr_a[i] = src_addr[i*ADDR_W +: ADDR_W];
    assign op_a[i]   = src_op[i*OP_W +: OP_W];
    assign data_a[i] = src_data[i*DATA_W +: DATA_W];
  end

  // Scan from the farthest offset down so the channel nearest ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(ptr_q) + k) % NUM_SRC);
      if (src_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign accept = rst_n & ~full & grant_vld;
  assign flit   = {addr_a[grant_idx], op_a[grant_idx], data_a[grant_idx]};
  assign pop    = pkt_valid & pkt_ready;

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign sent_d = pop ? sent_q + 1'b1 : sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      sent_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sent_q <= sent_d;
    end
  end

  pkt_sync_fifo #(.WIDTH(SRC_W + PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (accept),
    .push_data_i ({grant_idx, flit}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count)
  );

  assign pkt_valid = ~empty;
  assign pkt_data  = head[PKT_W-1:0];
  assign pkt_src   = head[PKT_W +: SRC_W];
  assign sent_cnt  = sent_q;
endmodule

// File: tb/tb_packetizer_rr_fifo.sv
// tb/tb_packetizer_rr_fifo.sv - self-checking bench for packetizer_rr_fifo
module tb_packetizer_rr_fifo;
  localparam int NS = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_valid, src_ready;
  logic [15:0] src_addr, src_op;
  logic [99:0] src_data;
  logic        pkt_valid, pkt_ready;
  logic [32:0] pkt_data;
  logic [1:0]  pkt_src;
  logic [2:0]  fifo_count;
  logic [3:0]  sent_cnt;
  logic [3:0]  a [4];
  logic [3:0]  o [4];
  logic [24:0] d [4];

  logic        sv1, sr1, pv1, pr1;
  logic [3:0]  a1, o1;
  logic [24:0] d1;
  logic [32:0] pd1;
  logic [0:0]  ps1;
  logic [2:0]  fc1;
  logic [15:0] sc1;

  always #5 clk = ~clk;

  always_comb begin
    src_addr = {a[3], a[2], a[1], a[0]};
    src_op   = {o[3], o[2], o[1], o[0]};
    src_data = {d[3], d[2], d[1], d[0]};
  end

  packetizer_rr_fifo #(.NUM_SRC(4), .ADDR_W(4), .OP_W(4), .DATA_W(25),
                       .FIFO_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_op(src_op), .src_data(src_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_src(pkt_src), .fifo_count(fifo_count), .sent_cnt(sent_cnt)
  );

  packetizer_rr_fifo #(.NUM_SRC(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .src_valid(sv1), .src_ready(sr1),
    .src_addr(a1), .src_op(o1), .src_data(d1),
    .pkt_valid(pv1), .pkt_ready(pr1), .pkt_data(pd1),
    .pkt_src(ps1), .fifo_count(fc1), .sent_cnt(sc1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  logic [34:0] sb_q [$];
  logic [34:0] e;
  logic [3:0]  exp_rdy;
  logic [3:0]  m_sent;
  int          m_ptr, m_count, g, idx;
  bit          popped;

  // Reference model advances once per cycle, predicting the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_fifo_count", 64'(fifo_count), 0);
      chk("rst_pkt_valid", 64'(pkt_valid), 0);
      chk("rst_sent_cnt", 64'(sent_cnt), 0);
      chk("rst_src_ready", 64'(src_ready), 0);
      chk("rst_pkt_data", 64'(pkt_data), 0);
      chk("rst_pkt_src", 64'(pkt_src), 0);
      m_ptr = 0; m_count = 0; m_sent = '0;
      sb_q.delete();
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_count < FD) begin
        for (int k = NS - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % NS;
          if (src_valid[idx[1:0]]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
      chk("src_ready", 64'(src_ready), 64'(exp_rdy));
      chk("pkt_valid", 64'(pkt_valid), 64'(m_count != 0));
      chk("fifo_count", 64'(fifo_count), 64'(m_count));
      chk("sent_cnt", 64'(sent_cnt), 64'(m_sent));
      popped = (m_count != 0) && pkt_ready;
      if (popped && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_pkt_data", 64'(pkt_data), 64'(e[32:0]));
        chk("sb_pkt_src", 64'(pkt_src), 64'(e[34:33]));
        m_sent = m_sent + 4'd1;
      end
      if (g >= 0) begin
        sb_q.push_back({g[1:0], a[g[1:0]], o[g[1:0]], d[g[1:0]]});
        m_ptr = (g + 1) % NS;
      end
      m_count = m_count + ((g >= 0) ? 1 : 0) - (popped ? 1 : 0);
    end
    if (rst_n && pv1) chk("one_pkt_src", 64'(ps1), 0);
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      sv1 = 1'($urandom); pr1 = 1'($urandom);
      a1 = 4'($urandom); o1 = 4'($urandom); d1 = 25'($urandom);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    src_valid = '0;
    pkt_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (fifo_count != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(fifo_count), 0);
    step();
  endtask

  typedef struct {
    int          ch;
    logic [3:0]  addr;
    logic [3:0]  op;
    logic [24:0] data;
    logic [32:0] exp_flit;
  } vec_t;

  vec_t vecs [5];
  int   k, n;
  bit   acc;

  initial begin
    vecs[0] = '{2, 4'hA, 4'h3, 25'h1FFFFFF, 33'h1_47FF_FFFF};
    vecs[1] = '{0, 4'h0, 4'h0, 25'h0000000, 33'h0_0000_0000};
    vecs[2] = '{3, 4'hF, 4'hF, 25'h1FFFFFF, 33'h1_FFFF_FFFF};
    vecs[3] = '{1, 4'h5, 4'hA, 25'h0ABCDEF, 33'h0_B4AB_CDEF};
    vecs[4] = '{0, 4'h1, 4'h8, 25'h1000000, 33'h0_3100_0000};

    for (int i = 0; i < 4; i++) begin a[i] = '0; o[i] = '0; d[i] = '0; end
    src_valid = '0; pkt_ready = 1'b0;
    sv1 = 1'b0; pr1 = 1'b0; a1 = '0; o1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset with three flits queued
    a[1] = 4'h6; o[1] = 4'h2; src_valid = 4'b0010;
    for (int j = 1; j <= 3; j++) begin d[1] = 25'(j); step(); end
    src_valid = '0;
    @(negedge clk);
    chk("t1_count_before_reset", 64'(fifo_count), 3);
    step();
    src_valid = 4'b0010;
    rst_n = 1'b0;
    #1;
    chk("t1_async_count", 64'(fifo_count), 0);
    chk("t1_async_valid", 64'(pkt_valid), 0);
    chk("t1_async_sent", 64'(sent_cnt), 0);
    chk("t1_async_ready", 64'(src_ready), 0);
    step();
    rst_n = 1'b1;

    // Fairness from ptr=0
    for (int i = 0; i < 4; i++) d[i] = 25'(16 + i);
    src_valid = 4'hF; pkt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_grant_order", 64'(src_ready), 64'(1 << (i % 4)));
      step();
    end
    drain();

    // Single-beat vectors: flit must appear one clock after accept
    for (int i = 0; i < 5; i++) begin
      a[vecs[i].ch] = vecs[i].addr;
      o[vecs[i].ch] = vecs[i].op;
      d[vecs[i].ch] = vecs[i].data;
      src_valid = 4'(1 << vecs[i].ch);
      pkt_ready = 1'b1;
      step();
      src_valid = '0;
      @(negedge clk);
      chk("t2_latency_valid", 64'(pkt_valid), 1);
      chk("t2_pkt_data", 64'(pkt_data), 64'(vecs[i].exp_flit));
      chk("t2_pkt_src", 64'(pkt_src), 64'(vecs[i].ch));
      step();
    end

    // Backpressure: fill to full, head must hold
    pkt_ready = 1'b0; a[1] = 4'h2; o[1] = 4'h7; src_valid = 4'b0010;
    k = 1; d[1] = 25'(k);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); acc = src_ready[1];
      step();
      if (acc) begin k++; d[1] = 25'(k); end
    end
    @(negedge clk);
    chk("t4_accepted", 64'(k), 5);
    chk("t4_full_count", 64'(fifo_count), 4);
    chk("t4_full_ready", 64'(src_ready), 0);
    chk("t4_head", 64'(pkt_data), 64'(33'h0_4E00_0001));
    step();
    @(negedge clk);
    chk("t4_head_held", 64'(pkt_data), 64'(33'h0_4E00_0001));
    step();
    pkt_ready = 1'b1;
    n = 0;
    while (k <= 6 && n < 20) begin
      @(negedge clk); acc = src_ready[1];
      step();
      if (acc) begin k++; d[1] = 25'(k); end
      n++;
    end
    chk("t4_stream_done", 64'(k), 7);
    drain();

    // Steady push+pop at count 2
    pkt_ready = 1'b0; a[0] = 4'h3; o[0] = 4'h1; src_valid = 4'b0001;
    d[0] = 25'd100; step();
    d[0] = 25'd101; step();
    d[0] = 25'd102; pkt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_count_steady", 64'(fifo_count), 2);
      step();
      d[0] = d[0] + 25'd1;
    end
    drain();

    // sent_cnt wrap with a 4-bit counter
    rst_n = 1'b0; step(); rst_n = 1'b1;
    src_valid = 4'hF; pkt_ready = 1'b1;
    repeat (17) step();
    drain();
    chk("t6_sent_wrap", 64'(sent_cnt), 1);
    chk("sb_empty", 64'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
